// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
// Read-side drain controller for a synchronous FIFO with a one-cycle registered
// read. It pops words whenever there is room downstream and presents them on a
// valid/ready stream, framed into BURST_LEN-word bursts with an end-of-burst
// marker. A 2-entry skid buffer covers the FIFO read latency, which keeps full
// throughput under backpressure.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   enable         allows new FIFO reads
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     FIFO read strobe (combinational, depends on m_ready)
//   fifo_dout      FIFO read data, valid the cycle after an accepted read
//   m_valid        output word available
//   m_ready        consumer accepts the word
//   m_data         output word (skid buffer head), 0 when m_valid is low
//   m_last         head word is the last beat of a burst
//   words_drained  running count of words accepted by the consumer, wrapping
//   idle           nothing buffered and no read in flight
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_drained,
  output logic                  idle
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] skid0_p2;
  logic [DATA_WIDTH-1:0] skid1_p2;
  logic [1:0]            skid_cnt;
  logic                  inflight_p1;
  logic [BEAT_W-1:0]     beat;
  logic                  pop;
  logic [2:0]            credit;
  logic [1:0]            wr_idx;

  assign pop = m_valid & m_ready;

  // Slots still committed after this cycle: buffered plus in flight, minus the
  // word leaving now. Counting the pop lets a read issue in the same cycle the
  // consumer frees a slot, which is what sustains full rate.
  assign credit     = {1'b0, skid_cnt} + {2'b00, inflight_p1} - {2'b00, pop};
  assign fifo_rd_en = rst_n & enable & ~fifo_empty & (credit < 3'd2);

  // Tail slot for an arriving word, after any shift caused by a pop.
  assign wr_idx = skid_cnt - 2'(pop);

  // Stage p1: read issued last cycle, data arriving now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt      <= 2'd0;
      inflight_p1   <= 1'b0;
      beat          <= '0;
      words_drained <= '0;
    end else begin
      skid_cnt    <= skid_cnt + 2'(inflight_p1) - 2'(pop);
      inflight_p1 <= fifo_rd_en;
      if (pop) begin
        beat          <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
        words_drained <= words_drained + CNT_WIDTH'(1);
      end
    end
  end

  // Stage p2: skid buffer, head in skid0_p2
  always_ff @(posedge clk) begin
    if (pop) begin
      skid0_p2 <= skid1_p2;
    end
    if (inflight_p1) begin
      if (wr_idx == 2'd0) begin
        skid0_p2 <= fifo_dout;
      end else begin
        skid1_p2 <= fifo_dout;
      end
    end
  end

  assign m_valid = (skid_cnt != 2'd0);
  assign m_data  = m_valid ? skid0_p2 : '0;
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign idle    = (skid_cnt == 2'd0) & ~inflight_p1;

  skid_overflow_a : assert property (@(posedge clk) disable iff (!rst_n) skid_cnt <= 2'd2);

endmodule
